// File: rtl/io_bus_bridge.sv
// io_bus_bridge: byte-stream command bridge to a 16-entry, 32-bit register bus.
// A command byte selects read or write and an address. Writes take 4 payload
// bytes, MSB first. Every command ends in a response burst on the TX stream:
// 0xA5 after a write, the 4 read-data bytes after a read, and 0xEE when the
// command is invalid or a payload stalls for too long.
module io_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic        WE,
  output logic [3:0]  A,
  output logic [31:0] WD,
  input  logic [31:0] RD,
  output logic        BUSY,
  output logic        OVERRUN
);

  // The counter must be able to hold TIMEOUT_CYCLES itself, because it
  // saturates there.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYCLES);

  localparam logic [7:0] RESP_WR_OK = 8'hA5;
  localparam logic [7:0] RESP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    a_q, a_d;
  logic [31:0]   wd_q, wd_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  // resp_q holds the response bytes still queued behind the one on TX_DATA.
  // left_q counts how many of them remain.
  logic [23:0]   resp_q, resp_d;
  logic [1:0]    left_q, left_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  // armed_q is low only for the first edge after reset is released. Any
  // byte that arrives on that edge is ignored.
  logic          armed_q, armed_d;
  logic          rx_ok;

  assign rx_ok = RX_VALID && armed_q;

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    wd_d       = wd_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    resp_d     = resp_q;
    left_d     = left_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    we_d       = 1'b0;
    overrun_d  = 1'b0;
    armed_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rx_ok) begin
          if (RX_DATA[6:4] != 3'b000) begin
            tx_data_d  = RESP_ERR;
            left_d     = 2'd0;
            tx_valid_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            a_d = RX_DATA[3:0];
            if (RX_DATA[7]) begin
              byte_cnt_d = 2'd0;
              tmo_cnt_d  = '0;
              state_d    = ST_PAYLOAD;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        // An arriving byte takes priority over a timeout in the same cycle.
        if (rx_ok) begin
          wd_d      = {wd_q[23:0], RX_DATA};
          tmo_cnt_d = '0;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            state_d = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (tmo_cnt_q >= TMO_LAST) begin
          // Abort the command. WD keeps whatever partial value it holds.
          tmo_cnt_d  = TMO_MAX;
          tx_data_d  = RESP_ERR;
          left_d     = 2'd0;
          tx_valid_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_WRITE: begin
        tx_data_d  = RESP_WR_OK;
        left_d     = 2'd0;
        tx_valid_d = 1'b1;
        state_d    = ST_RESP;
      end

      ST_READ: begin
        // The responder is zero-wait, so RD is sampled directly here.
        tx_data_d  = RD[31:24];
        resp_d     = RD[23:0];
        left_d     = 2'd3;
        tx_valid_d = 1'b1;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        if (TX_READY) begin
          if (left_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            tx_data_d = resp_q[23:16];
            resp_d    = {resp_q[15:0], 8'h00};
            left_d    = left_q - 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Bytes that arrive while a command is in progress are dropped and
    // reported.
    if (RX_VALID && (state_q == ST_WRITE || state_q == ST_READ ||
                     state_q == ST_RESP)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // All state lives here. Reset is asynchronous, so it clears outputs at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      a_q        <= 4'h0;
      wd_q       <= 32'h0000_0000;
      byte_cnt_q <= 2'd0;
      tmo_cnt_q  <= '0;
      resp_q     <= 24'h00_0000;
      left_q     <= 2'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      wd_q       <= wd_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      resp_q     <= resp_d;
      left_q     <= left_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      armed_q    <= armed_d;
    end
  end

  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign WE       = we_q;
  assign A        = a_q;
  assign WD       = wd_q;
  assign BUSY     = busy_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Bench for io_bus_bridge. TX bytes are checked against a scoreboard queue
// that is filled when a command is issued.
module tb_io_bus_bridge;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        WE;
  logic [3:0]  A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        BUSY;
  logic        OVERRUN;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_wd = 32'h0;

  io_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .WE(WE),
    .A(A), .WD(WD), .RD(RD), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (WE === 1'b1) we_count++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00; TX_READY = 1'b1; RD = 32'h0;
    tick(); tick();
    checks++; if ({WE, TX_VALID, BUSY, OVERRUN} !== 4'b0000) begin failures++;
      $display("FAIL reset_ctrl: we/txv/busy/ovr=%b expected 0000", {WE, TX_VALID, BUSY, OVERRUN}); end
    checks++; if (A !== 4'h0 || WD !== 32'h0 || TX_DATA !== 8'h00) begin failures++;
      $display("FAIL reset_data: A=%h WD=%h TX=%h expected 0/0/0", A, WD, TX_DATA); end
    // Release reset with a byte present. That byte must be ignored.
    RX_DATA = 8'h40; RX_VALID = 1'b1; RESET_N = 1'b1;
    tick();
    RX_VALID = 1'b0;
    checks++; if (BUSY !== 1'b0 || TX_VALID !== 1'b0) begin failures++;
      $display("FAIL reset_release_byte: busy=%b txv=%b expected 0/0", BUSY, TX_VALID); end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_write();
    logic [7:0] e;
    int budget;
    TX_READY = 1'b1;
    send_byte(8'h80);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++; if (WE !== 1'b0) begin failures++;
      $display("FAIL write_early_we: WE=%b expected 0", WE); end
    send_byte(8'h5A);
    exp_wd = 32'h0000005A;
    exp_q.push_back(8'hA5);
    checks++; if (WE !== 1'b1 || A !== 4'h0 || WD !== exp_wd) begin failures++;
      $display("FAIL write_strobe: WE=%b A=%h WD=%h expected 1/0/%h", WE, A, WD, exp_wd); end
    tick();
    checks++; if (WE !== 1'b0) begin failures++;
      $display("FAIL write_we_len: WE=%b expected 0", WE); end
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      if (TX_VALID && TX_READY) begin
        e = exp_q.pop_front();
        checks++; if (TX_DATA !== e) begin failures++;
          $display("FAIL write_resp: TX=%h expected %h", TX_DATA, e); end
      end
      tick(); budget--;
    end
    checks++; if (exp_q.size() != 0) begin failures++;
      $display("FAIL write_drain: %0d bytes left expected 0", exp_q.size()); exp_q.delete(); end
    checks++; if (BUSY !== 1'b0 || TX_VALID !== 1'b0) begin failures++;
      $display("FAIL write_idle: busy=%b txv=%b expected 0/0", BUSY, TX_VALID); end
    $display("test_write done");
  endtask

  task automatic test_read();
    logic [7:0] e;
    TX_READY = 1'b1;
    RD = 32'h0000001F;
    send_byte(8'h01);
    checks++; if (A !== 4'h1 || BUSY !== 1'b1 || TX_VALID !== 1'b0) begin failures++;
      $display("FAIL read_cycle: A=%h busy=%b txv=%b expected 1/1/0", A, BUSY, TX_VALID); end
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h1F);
    tick();
    RD = 32'hDEADBEEF;  // must not affect the already-captured response
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++; if (TX_VALID !== 1'b1 || TX_DATA !== e) begin failures++;
        $display("FAIL read_byte%0d: txv=%b TX=%h expected 1/%h", i, TX_VALID, TX_DATA, e); end
      tick();
    end
    checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b0) begin failures++;
      $display("FAIL read_end: txv=%b busy=%b expected 0/0", TX_VALID, BUSY); end
    $display("test_read done");
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    logic [7:0] hold;
    logic hold_v;
    int cyc;
    TX_READY = 1'b1;
    RD = 32'h12345678;
    send_byte(8'h02);
    exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    tick();
    RD = 32'h0;
    cyc = 0; hold_v = 1'b0; hold = 8'h00;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (hold_v) begin
        checks++; if (TX_DATA !== hold || TX_VALID !== 1'b1) begin failures++;
          $display("FAIL bp_stable: TX=%h txv=%b expected %h/1", TX_DATA, TX_VALID, hold); end
      end
      TX_READY = (cyc % 2 == 0);
      hold_v = TX_VALID && !TX_READY;
      hold = TX_DATA;
      if (TX_VALID && TX_READY) begin
        e = exp_q.pop_front();
        checks++; if (TX_DATA !== e) begin failures++;
          $display("FAIL bp_data: TX=%h expected %h", TX_DATA, e); end
      end
      tick(); cyc++;
    end
    checks++; if (exp_q.size() != 0) begin failures++;
      $display("FAIL bp_drain: %0d bytes left expected 0", exp_q.size()); exp_q.delete(); end
    checks++; if (TX_VALID !== 1'b0) begin failures++;
      $display("FAIL bp_extra: txv=%b expected 0 (duplicate byte)", TX_VALID); end
    TX_READY = 1'b1;
    $display("test_backpressure done");
  endtask

  task automatic test_invalid_timeout();
    logic [7:0] e;
    int n;
    int we_before;
    TX_READY = 1'b1;
    send_byte(8'h40);
    exp_q.push_back(8'hEE);
    checks++; if (TX_VALID !== 1'b1 || A !== 4'h2) begin failures++;
      $display("FAIL invalid_resp: txv=%b A=%h expected 1/2", TX_VALID, A); end
    e = exp_q.pop_front();
    checks++; if (TX_DATA !== e) begin failures++;
      $display("FAIL invalid_data: TX=%h expected %h", TX_DATA, e); end
    tick();
    checks++; if (BUSY !== 1'b0) begin failures++;
      $display("FAIL invalid_idle: busy=%b expected 0", BUSY); end
    // Stall after the first payload byte and expect an abort 16 cycles later.
    we_before = we_count;
    send_byte(8'h8F);
    send_byte(8'h11);
    exp_wd = {exp_wd[23:0], 8'h11};
    exp_q.push_back(8'hEE);
    n = 0;
    while (TX_VALID !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 16) begin failures++;
      $display("FAIL timeout_latency: %0d cycles expected 16", n); end
    checks++; if (we_count != we_before || WD !== exp_wd || A !== 4'hF) begin failures++;
      $display("FAIL timeout_state: we_pulses=%0d WD=%h A=%h expected 0/%h/f",
               we_count - we_before, WD, A, exp_wd); end
    e = exp_q.pop_front();
    checks++; if (TX_DATA !== e) begin failures++;
      $display("FAIL timeout_data: TX=%h expected %h", TX_DATA, e); end
    tick();
    // A byte that lands on the timeout edge is accepted instead.
    send_byte(8'h81);
    send_byte(8'hA1); exp_wd = {exp_wd[23:0], 8'hA1};
    for (int i = 0; i < 15; i++) tick();
    send_byte(8'hA2); exp_wd = {exp_wd[23:0], 8'hA2};
    checks++; if (TX_VALID !== 1'b0 || BUSY !== 1'b1) begin failures++;
      $display("FAIL timeout_race: txv=%b busy=%b expected 0/1", TX_VALID, BUSY); end
    send_byte(8'hA3); exp_wd = {exp_wd[23:0], 8'hA3};
    send_byte(8'hA4); exp_wd = {exp_wd[23:0], 8'hA4};
    checks++; if (WE !== 1'b1 || A !== 4'h1 || WD !== exp_wd) begin failures++;
      $display("FAIL timeout_race_write: WE=%b A=%h WD=%h expected 1/1/%h", WE, A, WD, exp_wd); end
    exp_q.push_back(8'hA5);
    tick();
    e = exp_q.pop_front();
    checks++; if (TX_VALID !== 1'b1 || TX_DATA !== e) begin failures++;
      $display("FAIL timeout_race_resp: txv=%b TX=%h expected 1/%h", TX_VALID, TX_DATA, e); end
    tick();
    $display("test_invalid_timeout done");
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    int budget;
    TX_READY = 1'b0;
    RD = 32'hCAFEF00D;
    send_byte(8'h03);
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE); exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    tick();
    RD = 32'h0;
    send_byte(8'h00);
    checks++; if (OVERRUN !== 1'b1 || TX_VALID !== 1'b1 || TX_DATA !== 8'hCA) begin failures++;
      $display("FAIL overrun_pulse: ovr=%b txv=%b TX=%h expected 1/1/ca", OVERRUN, TX_VALID, TX_DATA); end
    tick();
    checks++; if (OVERRUN !== 1'b0 || A !== 4'h3) begin failures++;
      $display("FAIL overrun_len: ovr=%b A=%h expected 0/3", OVERRUN, A); end
    TX_READY = 1'b1;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      if (TX_VALID && TX_READY) begin
        e = exp_q.pop_front();
        checks++; if (TX_DATA !== e) begin failures++;
          $display("FAIL overrun_resp: TX=%h expected %h", TX_DATA, e); end
      end
      tick(); budget--;
    end
    checks++; if (exp_q.size() != 0 || BUSY !== 1'b0) begin failures++;
      $display("FAIL overrun_drain: left=%0d busy=%b expected 0/0", exp_q.size(), BUSY); exp_q.delete(); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid_command();
    logic [7:0] e;
    int we_before;
    TX_READY = 1'b1;
    we_before = we_count;
    send_byte(8'h85); send_byte(8'hAA); send_byte(8'hBB);
    RESET_N = 1'b0;
    #1;
    checks++; if ({WE, TX_VALID, BUSY, OVERRUN} !== 4'b0000 || A !== 4'h0 || WD !== 32'h0) begin failures++;
      $display("FAIL midreset_async: ctrl=%b A=%h WD=%h expected 0000/0/0",
               {WE, TX_VALID, BUSY, OVERRUN}, A, WD); end
    tick(); tick();
    RESET_N = 1'b1;
    tick();
    checks++; if (we_count != we_before || TX_VALID !== 1'b0) begin failures++;
      $display("FAIL midreset_quiet: we_pulses=%0d txv=%b expected 0/0", we_count - we_before, TX_VALID); end
    send_byte(8'h87);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    exp_q.push_back(8'hA5);
    checks++; if (WE !== 1'b1 || A !== 4'h7 || WD !== 32'h11223344) begin failures++;
      $display("FAIL midreset_write: WE=%b A=%h WD=%h expected 1/7/11223344", WE, A, WD); end
    tick();
    e = exp_q.pop_front();
    checks++; if (TX_VALID !== 1'b1 || TX_DATA !== e) begin failures++;
      $display("FAIL midreset_resp: txv=%b TX=%h expected 1/%h", TX_VALID, TX_DATA, e); end
    tick();
    checks++; if (BUSY !== 1'b0) begin failures++;
      $display("FAIL midreset_idle: busy=%b expected 0", BUSY); end
    $display("test_reset_mid_command done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_invalid_timeout();
    test_overrun();
    test_reset_mid_command();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
